// File: rtl/ex_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_wb_stage_if
//  Description : EX-side control/operand bundle and WB-side result bundle of
//                the execute-to-writeback boundary, including GPIO pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_wb_stage_if #(
  parameter int WIDTH = 32
);
  // EX-stage inputs
  logic             flush_EX;
  logic             regwrite_EX;
  logic [1:0]       regsel_EX;
  logic             enhilo_EX;
  logic             rdrt_EX;
  logic             gpio_out_EX;
  logic             gpio_in_EX;
  logic [4:0]       rs_EX;
  logic [4:0]       rt_EX;
  logic [4:0]       rd_EX;
  logic [WIDTH-1:0] readdata1_EX;
  logic [WIDTH-1:0] readdata2_EX;
  logic [WIDTH-1:0] lo_EX;
  logic [WIDTH-1:0] hi_EX;
  logic [WIDTH-1:0] gpio_in;

  // WB-stage / architectural outputs
  logic             regwrite_WB;
  logic [4:0]       writeaddr_WB;
  logic [WIDTH-1:0] writedata_WB;
  logic [WIDTH-1:0] fwd_a_EX;
  logic [WIDTH-1:0] fwd_b_EX;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] gpio_out;

  // Pipeline side that issues EX instructions and observes results
  modport master (
    output flush_EX, regwrite_EX, regsel_EX, enhilo_EX, rdrt_EX,
           gpio_out_EX, gpio_in_EX, rs_EX, rt_EX, rd_EX,
           readdata1_EX, readdata2_EX, lo_EX, hi_EX, gpio_in,
    input  regwrite_WB, writeaddr_WB, writedata_WB, fwd_a_EX, fwd_b_EX,
           hi_q, lo_q, gpio_out
  );

  // The EX/WB stage itself
  modport slave (
    input  flush_EX, regwrite_EX, regsel_EX, enhilo_EX, rdrt_EX,
           gpio_out_EX, gpio_in_EX, rs_EX, rt_EX, rd_EX,
           readdata1_EX, readdata2_EX, lo_EX, hi_EX, gpio_in,
    output regwrite_WB, writeaddr_WB, writedata_WB, fwd_a_EX, fwd_b_EX,
           hi_q, lo_q, gpio_out
  );
endinterface
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_wb_stage
//  Description : Execute-to-writeback boundary of a 3-stage MIPS pipeline.
//                Owns HI/LO and the GPIO output register, synchronises GPIO
//                input pins, registers the writeback packet and forwards the
//                WB result to the rs/rt operands of the instruction in EX.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_wb_stage #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ex_wb_stage_if.slave bus
);

  localparam logic [1:0] c_SEL_HI = 2'd1;
  localparam logic [1:0] c_SEL_LO = 2'd2;

  logic                               r_regwrite_wb;
  logic [4:0]                         r_writeaddr_wb;
  logic [WIDTH-1:0]                   r_writedata_wb;
  logic [WIDTH-1:0]                   r_hi;
  logic [WIDTH-1:0]                   r_lo;
  logic [WIDTH-1:0]                   r_gpio_out;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  r_sync;

  logic                               w_valid;
  logic [4:0]                         w_addr;
  logic [WIDTH-1:0]                   w_fwd_a;
  logic [WIDTH-1:0]                   w_fwd_b;
  logic [WIDTH-1:0]                   w_wdata;

  assign w_valid = ~bus.flush_EX;
  assign w_addr  = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;

  // WB->EX bypass; $0 never matches because its write enable is never set
  always_comb begin
    w_fwd_a = bus.readdata1_EX;
    w_fwd_b = bus.readdata2_EX;
    if (r_regwrite_wb && (r_writeaddr_wb == bus.rs_EX)) w_fwd_a = r_writedata_wb;
    if (r_regwrite_wb && (r_writeaddr_wb == bus.rt_EX)) w_fwd_b = r_writedata_wb;
  end

  // Writeback data select: GPIO read beats GPIO write beats HI/LO moves
  always_comb begin
    w_wdata = bus.lo_EX;
    if (bus.gpio_in_EX)                w_wdata = r_sync[SYNC_STAGES-1];
    else if (bus.gpio_out_EX)          w_wdata = w_fwd_b;
    else if (bus.regsel_EX == c_SEL_HI) w_wdata = r_hi;
    else if (bus.regsel_EX == c_SEL_LO) w_wdata = r_lo;
  end

  // Writeback packet register; address/data load every cycle, enable is qualified
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwrite_wb  <= 1'b0;
      r_writeaddr_wb <= '0;
      r_writedata_wb <= '0;
    end else begin
      r_regwrite_wb  <= w_valid & bus.regwrite_EX & (w_addr != 5'd0);
      r_writeaddr_wb <= w_addr;
      r_writedata_wb <= w_wdata;
    end
  end

  // Architectural HI/LO, loaded by mult/multu
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_valid && bus.enhilo_EX) begin
      r_hi <= bus.hi_EX;
      r_lo <= bus.lo_EX;
    end
  end

  // GPIO output register, driven from the forwarded rt operand
  always_ff @(posedge clk) begin
    if (rst)                                r_gpio_out <= '0;
    else if (w_valid && bus.gpio_out_EX)    r_gpio_out <= w_fwd_b;
  end

  // Free-running synchroniser chain for the asynchronous GPIO pins
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.gpio_in};
  end

  assign bus.regwrite_WB  = r_regwrite_wb;
  assign bus.writeaddr_WB = r_writeaddr_wb;
  assign bus.writedata_WB = r_writedata_wb;
  assign bus.fwd_a_EX     = w_fwd_a;
  assign bus.fwd_b_EX     = w_fwd_b;
  assign bus.hi_q         = r_hi;
  assign bus.lo_q         = r_lo;
  assign bus.gpio_out     = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_wb_stage
//  Description : Scoreboard testbench for ex_wb_stage. A reference model
//                predicts each writeback packet when the EX instruction is
//                driven; the packet is popped and compared one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_wb_stage;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic             we;
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_wb_stage_if #(.WIDTH(WIDTH)) bus ();

  ex_wb_stage #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  pkt_t q_exp[$];

  // Reference state
  logic [WIDTH-1:0] m_hi, m_lo, m_gpo;
  logic [WIDTH-1:0] m_sync [SYNC_STAGES];
  pkt_t             m_wb;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hi  = '0;
    m_lo  = '0;
    m_gpo = '0;
    m_wb  = '0;
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = '0;
  endtask

  task automatic set_idle();
    bus.flush_EX     = 1'b0; bus.regwrite_EX = 1'b0; bus.regsel_EX  = 2'd0;
    bus.enhilo_EX    = 1'b0; bus.rdrt_EX     = 1'b0; bus.gpio_out_EX = 1'b0;
    bus.gpio_in_EX   = 1'b0; bus.rs_EX       = '0;   bus.rt_EX      = '0;
    bus.rd_EX        = '0;   bus.readdata1_EX = '0;  bus.readdata2_EX = '0;
    bus.lo_EX        = '0;   bus.hi_EX       = '0;
  endtask

  // Hold reset for two edges with whatever EX inputs are present; all state must clear
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", {31'd0, bus.regwrite_WB}, '0);
    chk("rst_addr",     {27'd0, bus.writeaddr_WB}, '0);
    chk("rst_data",     bus.writedata_WB, '0);
    chk("rst_hi",       bus.hi_q, '0);
    chk("rst_lo",       bus.lo_q, '0);
    chk("rst_gpio_out", bus.gpio_out, '0);
    model_clear();
    q_exp.delete();
    rst = 1'b0;
    set_idle();
  endtask

  // Issue one EX instruction (inputs already on the bus), predict, clock, compare
  task automatic ex_cycle();
    logic             v;
    logic [4:0]       addr;
    logic [WIDTH-1:0] efa, efb, ed;
    pkt_t             p, got;
    #1;
    efa = (m_wb.we && m_wb.addr == bus.rs_EX) ? m_wb.data : bus.readdata1_EX;
    efb = (m_wb.we && m_wb.addr == bus.rt_EX) ? m_wb.data : bus.readdata2_EX;
    chk("fwd_a", bus.fwd_a_EX, efa);
    chk("fwd_b", bus.fwd_b_EX, efb);

    v    = ~bus.flush_EX;
    addr = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;
    if (bus.gpio_in_EX)          ed = m_sync[SYNC_STAGES-1];
    else if (bus.gpio_out_EX)    ed = efb;
    else if (bus.regsel_EX == 1) ed = m_hi;
    else if (bus.regsel_EX == 2) ed = m_lo;
    else                         ed = bus.lo_EX;
    p.we   = v & bus.regwrite_EX & (addr != 5'd0);
    p.addr = addr;
    p.data = ed;
    q_exp.push_back(p);

    if (v && bus.enhilo_EX) begin m_hi = bus.hi_EX; m_lo = bus.lo_EX; end
    if (v && bus.gpio_out_EX) m_gpo = efb;
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = bus.gpio_in;
    m_wb = p;

    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got empty queue expected one packet");
    end else begin
      got.we   = bus.regwrite_WB;
      got.addr = bus.writeaddr_WB;
      got.data = bus.writedata_WB;
      p = q_exp.pop_front();
      chk("wb_regwrite", {31'd0, got.we}, {31'd0, p.we});
      chk("wb_addr",     {27'd0, got.addr}, {27'd0, p.addr});
      chk("wb_data",     got.data, p.data);
    end
    chk("hi_q",     bus.hi_q, m_hi);
    chk("lo_q",     bus.lo_q, m_lo);
    chk("gpio_out", bus.gpio_out, m_gpo);
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    bus.gpio_in = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // idle after reset
    ex_cycle();

    // add to $5, then same to $0 (suppressed)
    bus.regwrite_EX = 1; bus.rd_EX = 5'd5; bus.lo_EX = 32'h7; ex_cycle();
    chk("add_data_const", bus.writedata_WB, 32'h7);
    bus.regwrite_EX = 1; bus.rd_EX = 5'd0; bus.lo_EX = 32'h7; ex_cycle();

    // mult, mfhi, mflo
    bus.enhilo_EX = 1; bus.hi_EX = 32'h1; bus.lo_EX = 32'hFFFF_FFFE; ex_cycle();
    bus.regwrite_EX = 1; bus.regsel_EX = 2'd1; bus.rd_EX = 5'd2; bus.lo_EX = 32'h55; ex_cycle();
    chk("mfhi_const", bus.writedata_WB, 32'h1);
    bus.regwrite_EX = 1; bus.regsel_EX = 2'd2; bus.rd_EX = 5'd3; bus.lo_EX = 32'h55; ex_cycle();
    chk("mflo_const", bus.writedata_WB, 32'hFFFF_FFFE);

    // forwarding hit on rs, then miss
    bus.regwrite_EX = 1; bus.rdrt_EX = 1; bus.rt_EX = 5'd3; bus.lo_EX = 32'h10; ex_cycle();
    bus.rs_EX = 5'd3; bus.readdata1_EX = 32'h99; #1;
    chk("fwd_a_hit_const", bus.fwd_a_EX, 32'h10);
    ex_cycle();
    bus.regwrite_EX = 1; bus.rdrt_EX = 1; bus.rt_EX = 5'd3; bus.lo_EX = 32'h10; ex_cycle();
    bus.rs_EX = 5'd4; bus.readdata1_EX = 32'h99; ex_cycle();

    // GPIO write, with rt forwarded from the previous writer of $7
    bus.regwrite_EX = 1; bus.rd_EX = 5'd7; bus.lo_EX = 32'hA5A5; ex_cycle();
    bus.gpio_out_EX = 1; bus.regwrite_EX = 1; bus.rt_EX = 5'd7; bus.rd_EX = 5'd9;
    bus.readdata2_EX = 32'hDEAD; ex_cycle();
    chk("gpio_out_const", bus.gpio_out, 32'hA5A5);

    // GPIO read after the synchroniser has settled
    bus.gpio_in = 32'h1234;
    ex_cycle(); ex_cycle();
    bus.gpio_in_EX = 1; bus.regwrite_EX = 1; bus.rd_EX = 5'd8; ex_cycle();
    chk("gpio_in_const", bus.writedata_WB, 32'h1234);

    // GPIO read and write together
    bus.gpio_in_EX = 1; bus.gpio_out_EX = 1; bus.regwrite_EX = 1; bus.rd_EX = 5'd10;
    bus.rt_EX = 5'd11; bus.readdata2_EX = 32'hCAFE; ex_cycle();

    // flushed mult + GPIO write + regwrite: no effect
    bus.flush_EX = 1; bus.enhilo_EX = 1; bus.gpio_out_EX = 1; bus.regwrite_EX = 1;
    bus.rd_EX = 5'd12; bus.hi_EX = 32'hBAD0; bus.lo_EX = 32'hBAD1;
    bus.readdata2_EX = 32'hBAD2; ex_cycle();

    // mult with regwrite: both take effect
    bus.enhilo_EX = 1; bus.regwrite_EX = 1; bus.rd_EX = 5'd13;
    bus.hi_EX = 32'h0000_00AB; bus.lo_EX = 32'h0000_00CD; ex_cycle();

    // randomised mix with narrow address range to stress forwarding
    for (int k = 0; k < 60; k++) begin
      bus.flush_EX     = ($urandom_range(0, 3) == 0);
      bus.regwrite_EX  = $urandom_range(0, 1);
      bus.regsel_EX    = 2'($urandom_range(0, 3));
      bus.enhilo_EX    = ($urandom_range(0, 3) == 0);
      bus.rdrt_EX      = $urandom_range(0, 1);
      bus.gpio_out_EX  = ($urandom_range(0, 4) == 0);
      bus.gpio_in_EX   = ($urandom_range(0, 4) == 0);
      bus.rs_EX        = 5'($urandom_range(0, 5));
      bus.rt_EX        = 5'($urandom_range(0, 5));
      bus.rd_EX        = 5'($urandom_range(0, 5));
      bus.readdata1_EX = $urandom;
      bus.readdata2_EX = $urandom;
      bus.lo_EX        = $urandom;
      bus.hi_EX        = $urandom;
      bus.gpio_in      = $urandom;
      ex_cycle();
    end

    // reset coincident with a mult and a GPIO write
    bus.enhilo_EX = 1; bus.hi_EX = 32'h1111; bus.lo_EX = 32'h2222;
    bus.gpio_out_EX = 1; bus.readdata2_EX = 32'h3333; bus.regwrite_EX = 1; bus.rd_EX = 5'd4;
    do_reset();
    ex_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute-to-writeback boundary of the 3-stage MIPS pipeline (Fetch / EX / WB).
- Consumes the decoded EX control signals and the ALU hi/lo results, and owns the architectural HI/LO registers and the GPIO output register.
- Synchronises the GPIO input pins.
- Registers the writeback packet (address, data, enable) and supplies WB→EX forwarding for the rs/rt operands of the instruction currently in EX.

Parameters:
WIDTH, 32, datapath width of registers, GPIO and ALU results
SYNC_STAGES, 2, flip-flop depth of the gpio_in synchroniser (minimum 2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush_EX  in  1  turns the EX instruction into a bubble (no architectural effect)
regwrite_EX  in  1  EX instruction writes the register file
regsel_EX  in  2  0=ALU lo result, 1=HI register, 2=LO register, 3=reserved (treated as 0)
enhilo_EX  in  1  load HI/LO from ALU (mult/multu)
rdrt_EX  in  1  destination select: 1=rt, 0=rd
gpio_out_EX  in  1  GPIO write instruction (srl, shamt 0)
gpio_in_EX  in  1  GPIO read instruction (sra, shamt 0)
rs_EX  in  5  instruction[25:21]
rt_EX  in  5  instruction[20:16]
rd_EX  in  5  instruction[15:11]
readdata1_EX  in  WIDTH  regfile rs read value
readdata2_EX  in  WIDTH  regfile rt read value
lo_EX  in  WIDTH  ALU low result
hi_EX  in  WIDTH  ALU high result
gpio_in  in  WIDTH  asynchronous input pins
regwrite_WB  out  1  register-file write enable
writeaddr_WB  out  5  register-file write address
writedata_WB  out  WIDTH  register-file write data
fwd_a_EX  out  WIDTH  forwarded rs operand for the ALU
fwd_b_EX  out  WIDTH  forwarded rt operand for the ALU / GPIO source
hi_q  out  WIDTH  HI register
lo_q  out  WIDTH  LO register
gpio_out  out  WIDTH  GPIO output register

Behaviour:
- Reset (rst=1 at an edge): regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out and all synchroniser flops become 0. Reset wins over every other input, including mid-mult and mid-GPIO write.
- Valid qualifier: v = ~flush_EX. All architectural updates below require v=1. A flushed cycle loads regwrite_WB=0 and leaves hi_q, lo_q and gpio_out unchanged.
- Destination: addr = rdrt_EX ? rt_EX : rd_EX.
- Write-enable register: regwrite_WB <= v & regwrite_EX & (addr != 0). Writes to $0 are always suppressed.
- Write-address register: writeaddr_WB <= addr, loaded every non-reset cycle.
- Write-data mux, priority order (registered into writedata_WB):
  - gpio_in_EX=1: synchronised GPIO input (last synchroniser stage).
  - gpio_out_EX=1: fwd_b_EX, so rd receives the value driven out.
  - regsel_EX=1: hi_q; regsel_EX=2: lo_q, i.e. the current register values.
  - Otherwise: lo_EX.
- HI/LO: if v & enhilo_EX, hi_q <= hi_EX and lo_q <= lo_EX at the edge.
  - mfhi/mflo in the cycle immediately after mult therefore read the new value, with no stall.
  - mfhi/mflo in the same EX cycle as an HI/LO write is impossible (one instruction per EX cycle).
- GPIO out: if v & gpio_out_EX, gpio_out <= fwd_b_EX.
- GPIO in: SYNC_STAGES-deep flop chain on gpio_in, free-running. Latency from a pin change to visibility in writedata is SYNC_STAGES edges plus the WB register edge.
- Forwarding (combinational):
  - fwd_a_EX = (regwrite_WB & writeaddr_WB==rs_EX) ? writedata_WB : readdata1_EX.
  - fwd_b_EX uses the same rule with rt_EX and readdata2_EX.
  - rs/rt = 0 never forward, guaranteed by the $0 suppression.
- Latency: EX result visible on the WB outputs exactly 1 cycle after the EX cycle.
- Simultaneous events:
  - gpio_in_EX and gpio_out_EX both set: treated as GPIO read for writedata; gpio_out is still updated.
  - enhilo_EX with regwrite_EX set: both take effect.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0. Release with regwrite_EX=0 → regwrite_WB stays 0.
- add: rd_EX=5, rdrt_EX=0, regwrite_EX=1, lo_EX=0x0000_0007 → next cycle regwrite_WB=1, writeaddr_WB=5, writedata_WB=7. Repeat with rd_EX=0 → regwrite_WB=0.
- mult then mfhi/mflo: enhilo_EX=1, hi_EX=0x1, lo_EX=0xFFFF_FFFE → hi_q=1, lo_q=0xFFFF_FFFE. Next cycle regsel_EX=1 → writedata_WB=1; then regsel_EX=2 → 0xFFFF_FFFE.
- Forwarding: addi writes rt=3 with 0x10 in cycle n. In cycle n+1 the EX instruction has rs_EX=3, readdata1_EX=0x99 → fwd_a_EX=0x10. With rs_EX=4 → fwd_a_EX=0x99.
- GPIO write then read:
  - gpio_out_EX=1, rt value 0xA5A5 → gpio_out=0xA5A5 after 1 edge.
  - Drive gpio_in=0x1234, wait 2 edges, then gpio_in_EX=1, rd=8 → writedata_WB=0x1234, writeaddr_WB=8.
- Flush and reset mid-operation: flush_EX=1 with enhilo_EX=1 and gpio_out_EX=1 → hi_q, lo_q and gpio_out unchanged, regwrite_WB=0. rst=1 coincident with a mult → hi_q=lo_q=0.
